// File: rtl/pg_rule_unpacker_if.sv
// ============================================================================
//  Module      : pg_rule_unpacker_if
//  Description : Beat-in / rule-out stream bundle for the port-group rule
//                unpacker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pg_rule_unpacker_if;
    logic [127:0] in_usr_data;
    logic         in_usr_valid;
    logic         in_usr_sop;
    logic         in_usr_eop;
    logic [3:0]   in_usr_empty;
    logic         in_usr_ready;
    logic [15:0]  out_rule_id;
    logic         out_rule_valid;
    logic         out_rule_last;
    logic         out_rule_ready;

    modport slave (
        input  in_usr_data,
        input  in_usr_valid,
        input  in_usr_sop,
        input  in_usr_eop,
        input  in_usr_empty,
        output in_usr_ready,
        output out_rule_id,
        output out_rule_valid,
        output out_rule_last,
        input  out_rule_ready
    );

    modport master (
        output in_usr_data,
        output in_usr_valid,
        output in_usr_sop,
        output in_usr_eop,
        output in_usr_empty,
        input  in_usr_ready,
        input  out_rule_id,
        input  out_rule_valid,
        input  out_rule_last,
        output out_rule_ready
    );
endinterface

`default_nettype wire

// File: rtl/pg_rule_unpacker.sv
// ============================================================================
//  Module      : pg_rule_unpacker
//  Description : Serializes non-zero 16-bit rule slots of 128-bit beats into a
//                one-rule-per-cycle stream with one last word per packet.
//                Statistics counters enabled by PG_RULE_UNPACKER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pg_rule_unpacker #(
    parameter int RULE_AWIDTH = 13,
    parameter int NUM_SLOTS   = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pg_rule_unpacker_if.slave  bus,
    output logic [31:0]        pkt_cnt,
    output logic [31:0]        rule_cnt,
    output logic [31:0]        err_cnt
);

    localparam int                   c_SLOT_W = 16;
    localparam logic [NUM_SLOTS-1:0] c_ONE    = NUM_SLOTS'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    logic [RULE_AWIDTH-1:0] w_in_slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   w_in_mask;
    logic                   w_in_load;

    logic [RULE_AWIDTH-1:0] r_slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   r_mask;
    logic                   r_eop;
    logic                   r_term;

    logic                   w_loaded;
    logic [RULE_AWIDTH-1:0] w_sel;
    logic [NUM_SLOTS-1:0]   w_mask_clr;
    logic                   w_single;
    logic                   w_final;
    logic                   w_last;
    logic [c_SLOT_W-1:0]    w_id;
    logic                   w_out_hs;
    logic                   w_in_ready;
    logic                   w_in_hs;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_err;

    // Only the low RULE_AWIDTH bits of each slot carry the rule ID
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign w_in_slot[gi] = bus.in_usr_data[c_SLOT_W*gi +: RULE_AWIDTH];
            assign w_in_mask[gi] = |w_in_slot[gi];
        end
    endgenerate

    // An all-zero non-eop beat is swallowed without occupying the register
    assign w_in_load = (|w_in_mask) | bus.in_usr_eop;

    assign w_loaded = (|r_mask) | r_term;

    always_comb begin
        w_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_sel = r_slot[i];
            end
        end
    end

    assign w_mask_clr = r_mask & (r_mask - c_ONE);
    assign w_single   = (|r_mask) & ~(|w_mask_clr);
    assign w_final    = r_term | w_single;
    assign w_last     = r_term | (r_eop & w_single);
    assign w_id       = r_term ? '0 : {{(c_SLOT_W-RULE_AWIDTH){1'b0}}, w_sel};

    assign w_out_hs   = w_loaded & bus.out_rule_ready;
    // Accept a new beat in the same cycle the current one drains
    assign w_in_ready = ~w_loaded | (bus.out_rule_ready & w_final);
    assign w_in_hs    = bus.in_usr_valid & w_in_ready;

    assign bus.in_usr_ready   = w_in_ready;
    assign bus.out_rule_valid = w_loaded;
    assign bus.out_rule_id    = w_id;
    assign bus.out_rule_last  = w_loaded & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot[i] <= '0;
            end
            r_mask <= '0;
            r_eop  <= 1'b0;
            r_term <= 1'b0;
        end else if (w_in_hs && w_in_load) begin
            r_slot <= w_in_slot;
            r_mask <= w_in_mask;
            r_eop  <= bus.in_usr_eop;
            r_term <= bus.in_usr_eop & ~(|w_in_mask);
        end else if (w_out_hs) begin
            r_mask <= w_mask_clr;
            r_term <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Misframed beats are counted but otherwise handled as packet starts
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        if (w_in_hs) begin
            w_state_nxt = bus.in_usr_eop ? ST_IDLE : ST_IN_PKT;
            case (r_state)
                ST_IDLE:   w_err = ~bus.in_usr_sop;
                ST_IN_PKT: w_err = bus.in_usr_sop;
                default:   w_err = 1'b0;
            endcase
        end
    end

`ifdef PG_RULE_UNPACKER_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_rule_cnt;
    logic [31:0] r_err_cnt;
    logic        w_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt  <= '0;
            r_rule_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_out_hs && w_last) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_out_hs && (w_id != '0)) begin
                r_rule_cnt <= r_rule_cnt + 32'd1;
            end
            if (w_err) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign rule_cnt = r_rule_cnt;
    assign err_cnt  = r_err_cnt;
    assign w_unused = ^{bus.in_usr_empty, bus.in_usr_data};
`else
    logic w_unused;

    assign pkt_cnt  = '0;
    assign rule_cnt = '0;
    assign err_cnt  = '0;
    assign w_unused = ^{bus.in_usr_empty, bus.in_usr_data, w_err};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pg_rule_unpacker.sv
// ============================================================================
//  Module      : tb_pg_rule_unpacker
//  Description : Directed self-checking bench for pg_rule_unpacker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pg_rule_unpacker;

    logic        clk;
    logic        rst_n;
    logic [31:0] pkt_cnt;
    logic [31:0] rule_cnt;
    logic [31:0] err_cnt;

    int          total;
    int          bad;
    logic [31:0] exp_pkt;
    logic [31:0] exp_rule;
    logic [31:0] exp_err;

    pg_rule_unpacker_if bus ();

    pg_rule_unpacker #(
        .RULE_AWIDTH (13),
        .NUM_SLOTS   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .pkt_cnt  (pkt_cnt),
        .rule_cnt (rule_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] id, input logic last);
        chk({tag, "_valid"}, {31'd0, bus.out_rule_valid}, 32'd1);
        chk({tag, "_id"},    {16'd0, bus.out_rule_id},    {16'd0, id});
        chk({tag, "_last"},  {31'd0, bus.out_rule_last},  {31'd0, last});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.out_rule_valid}, 32'd0);
    endtask

    task automatic chk_cnts(input string tag);
`ifdef PG_RULE_UNPACKER_STATS_EN
        chk({tag, "_pkt"},  pkt_cnt,  exp_pkt);
        chk({tag, "_rule"}, rule_cnt, exp_rule);
        chk({tag, "_err"},  err_cnt,  exp_err);
`else
        chk({tag, "_pkt"},  pkt_cnt,  32'd0);
        chk({tag, "_rule"}, rule_cnt, 32'd0);
        chk({tag, "_err"},  err_cnt,  32'd0);
`endif
    endtask

    task automatic drive(input logic [127:0] d, input logic sop, input logic eop);
        bus.in_usr_data  = d;
        bus.in_usr_sop   = sop;
        bus.in_usr_eop   = eop;
        bus.in_usr_valid = 1'b1;
    endtask

    function automatic logic [15:0] full_id(input int k);
        return (k < 8) ? 16'(16'h0101 + k) : 16'(16'h0201 + (k - 8));
    endfunction

    initial begin
        logic [127:0] beat_a;
        logic [127:0] beat_b;
        int           k;
        int           cy;
        logic         drop;

        total    = 0;
        bad      = 0;
        exp_pkt  = '0;
        exp_rule = '0;
        exp_err  = '0;
        rst_n    = 1'b0;
        bus.in_usr_data    = '0;
        bus.in_usr_valid   = 1'b0;
        bus.in_usr_sop     = 1'b0;
        bus.in_usr_eop     = 1'b0;
        bus.in_usr_empty   = '0;
        bus.out_rule_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_idle("rst");
        chk("rst_id",    {16'd0, bus.out_rule_id},   32'd0);
        chk("rst_last",  {31'd0, bus.out_rule_last}, 32'd0);
        chk("rst_ready", {31'd0, bus.in_usr_ready},  32'd1);
        chk_cnts("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single sop&eop beat with scattered rules
        @(negedge clk);
        drive({16'h1FFF, 16'h0, 16'h0, 16'h0, 16'h0012, 16'h0, 16'h0005, 16'h0}, 1'b1, 1'b1);
        #1;
        chk("t1_ready0", {31'd0, bus.in_usr_ready}, 32'd1);
        @(negedge clk);
        bus.in_usr_valid = 1'b0;
        #1;
        chk_word("t1_w0", 16'h0005, 1'b0);
        chk("t1_ready1", {31'd0, bus.in_usr_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk_word("t1_w1", 16'h0012, 1'b0);
        @(negedge clk);
        #1;
        chk_word("t1_w2", 16'h1FFF, 1'b1);
        chk("t1_ready3", {31'd0, bus.in_usr_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk_idle("t1_end");
        exp_pkt  += 1;
        exp_rule += 3;
        chk_cnts("t1");

        // Bits above the rule-ID width are ignored
        @(negedge clk);
        drive({16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hA005, 16'hE000}, 1'b1, 1'b1);
        @(negedge clk);
        bus.in_usr_valid = 1'b0;
        #1;
        chk_word("t1b_w0", 16'h0005, 1'b1);
        @(negedge clk);
        #1;
        chk_idle("t1b_end");
        exp_pkt  += 1;
        exp_rule += 1;

        // Two beats, second all-zero with eop: terminator word
        @(negedge clk);
        drive({16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0004, 16'h0003}, 1'b1, 1'b0);
        @(negedge clk);
        drive('0, 1'b0, 1'b1);
        #1;
        chk_word("t2_w0", 16'h0003, 1'b0);
        chk("t2_ready0", {31'd0, bus.in_usr_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk_word("t2_w1", 16'h0004, 1'b0);
        chk("t2_ready1", {31'd0, bus.in_usr_ready}, 32'd1);
        @(negedge clk);
        bus.in_usr_valid = 1'b0;
        #1;
        chk_word("t2_term", 16'h0000, 1'b1);
        @(negedge clk);
        #1;
        chk_idle("t2_end");
        exp_pkt  += 1;
        exp_rule += 2;
        chk_cnts("t2");

        // Three all-zero beats: no bubbles, exactly one terminator
        @(negedge clk);
        drive('0, 1'b1, 1'b0);
        #1;
        chk("t3_ready0", {31'd0, bus.in_usr_ready}, 32'd1);
        @(negedge clk);
        drive('0, 1'b0, 1'b0);
        #1;
        chk("t3_ready1", {31'd0, bus.in_usr_ready}, 32'd1);
        chk_idle("t3_mid1");
        @(negedge clk);
        drive('0, 1'b0, 1'b1);
        #1;
        chk("t3_ready2", {31'd0, bus.in_usr_ready}, 32'd1);
        chk_idle("t3_mid2");
        @(negedge clk);
        bus.in_usr_valid = 1'b0;
        #1;
        chk_word("t3_term", 16'h0000, 1'b1);
        @(negedge clk);
        #1;
        chk_idle("t3_end");
        exp_pkt += 1;
        chk_cnts("t3");

        // Two full beats back to back, downstream always ready
        beat_a = {16'h0108, 16'h0107, 16'h0106, 16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101};
        beat_b = {16'h0208, 16'h0207, 16'h0206, 16'h0205, 16'h0204, 16'h0203, 16'h0202, 16'h0201};
        @(negedge clk);
        drive(beat_a, 1'b1, 1'b0);
        @(negedge clk);
        drive(beat_b, 1'b0, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            if (c == 9) begin
                bus.in_usr_valid = 1'b0;
            end
            #1;
            chk_word("t4a", full_id(c - 1), (c == 16));
            chk("t4a_ready", {31'd0, bus.in_usr_ready}, {31'd0, (c == 8) || (c == 16)});
            @(negedge clk);
        end
        #1;
        chk_idle("t4a_end");
        exp_pkt  += 1;
        exp_rule += 16;

        // Same two beats with downstream ready toggling every cycle
        @(negedge clk);
        drive(beat_a, 1'b1, 1'b0);
        @(negedge clk);
        drive(beat_b, 1'b0, 1'b1);
        k    = 0;
        cy   = 0;
        drop = 1'b0;
        while (k < 16 && cy < 40) begin
            bus.out_rule_ready = ((cy % 2) == 1);
            if (drop) begin
                bus.in_usr_valid = 1'b0;
            end
            #1;
            chk_word("t4b", full_id(k), (k == 15));
            chk("t4b_ready", {31'd0, bus.in_usr_ready},
                {31'd0, bus.out_rule_ready && ((k == 7) || (k == 15))});
            if (bus.out_rule_ready) begin
                if (k == 7) begin
                    drop = 1'b1;
                end
                k++;
            end
            cy++;
            @(negedge clk);
        end
        chk("t4b_count", 32'(k), 32'd16);
        bus.out_rule_ready = 1'b1;
        bus.in_usr_valid   = 1'b0;
        #1;
        chk_idle("t4b_end");
        exp_pkt  += 1;
        exp_rule += 16;
        chk_cnts("t4");

        // Framing errors: missing sop in IDLE, then sop inside a packet
        @(negedge clk);
        drive({112'd0, 16'h0011}, 1'b0, 1'b0);
        @(negedge clk);
        drive({112'd0, 16'h0022}, 1'b1, 1'b1);
        #1;
        chk_word("t5_w0", 16'h0011, 1'b0);
        chk("t5_ready", {31'd0, bus.in_usr_ready}, 32'd1);
        @(negedge clk);
        bus.in_usr_valid = 1'b0;
        #1;
        chk_word("t5_w1", 16'h0022, 1'b1);
        @(negedge clk);
        #1;
        chk_idle("t5_end");
        exp_pkt  += 1;
        exp_rule += 2;
        exp_err  += 2;
        chk_cnts("t5");

        // Reset with five rules pending
        @(negedge clk);
        bus.out_rule_ready = 1'b0;
        drive({16'h0, 16'h0, 16'h0, 16'h0035, 16'h0034, 16'h0033, 16'h0032, 16'h0031}, 1'b1, 1'b1);
        @(negedge clk);
        bus.in_usr_valid = 1'b0;
        #1;
        chk_word("t6_pre", 16'h0031, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("t6_rst");
        chk("t6_rst_ready", {31'd0, bus.in_usr_ready}, 32'd1);
        chk("t6_rst_last",  {31'd0, bus.out_rule_last}, 32'd0);
        exp_pkt  = '0;
        exp_rule = '0;
        exp_err  = '0;
        chk_cnts("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_rule_ready = 1'b1;
        @(negedge clk);
        drive({112'd0, 16'h0007}, 1'b1, 1'b1);
        @(negedge clk);
        bus.in_usr_valid = 1'b0;
        #1;
        chk_word("t6_w0", 16'h0007, 1'b1);
        @(negedge clk);
        #1;
        chk_idle("t6_end");
        exp_pkt  += 1;
        exp_rule += 1;
        chk_cnts("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
